alu_share_arbiter: RTL and testbench

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

---
 rtl/alu_share_arbiter.sv | 130 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU.
// One operation in flight: IDLE accepts, EXEC drives the ALU and captures, RESP holds the result.
module alu_share_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_sum,
  input  logic        alu_zout,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_zero,
  output logic        rsp_id,
  output logic        rsp_err
);

  localparam int unsigned DW  = 32;
  localparam int unsigned OPW = 3;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e           state_q, state_d;
  logic [OPW-1:0]   op_q;
  logic [DW-1:0]    a_q, b_q;
  logic             id_q;
  logic             last_grant_q;
  logic [DW-1:0]    rsp_data_q;
  logic             rsp_zero_q, rsp_id_q, rsp_err_q;
  logic             grant_c, hs_c, illegal_c;

  // Tie goes to the requester that was not served last (RR) or to requester 0.
  always_comb begin
    grant_c = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_c = RR_EN ? ~last_grant_q : 1'b0;
    end else begin
      grant_c = req1_valid;
    end
  end

  assign hs_c      = req0_ready | req1_ready;
  assign illegal_c = (op_q == OPW'(3'b011)) || (op_q == OPW'(3'b101));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    alu_op     = '0;
    unique case (state_q)
      IDLE: begin
        req0_ready = req0_valid && !grant_c;
        req1_ready = req1_valid &&  grant_c;
        if (req0_ready || req1_ready) state_d = EXEC;
      end
      EXEC: begin
        alu_a   = a_q;
        alu_b   = b_q;
        alu_op  = op_q;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch on handshake; result capture at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_data_q   <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      if (hs_c) begin
        op_q         <= grant_c ? req1_op : req0_op;
        a_q          <= grant_c ? req1_a  : req0_a;
        b_q          <= grant_c ? req1_b  : req0_b;
        id_q         <= grant_c;
        last_grant_q <= grant_c;
      end
      if (state_q == EXEC) begin
        rsp_id_q <= id_q;
        if (illegal_c) begin
          rsp_data_q <= '0;
          rsp_zero_q <= 1'b1;
          rsp_err_q  <= 1'b1;
        end else begin
          rsp_data_q <= alu_sum;
          rsp_zero_q <= alu_zout;
          rsp_err_q  <= 1'b0;
        end
      end
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench: vector table for single operations plus hand-written arbitration, backpressure and reset sequences.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, rsp_ready;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;

  logic        req0_ready, req1_ready, rsp_valid, rsp_zero, rsp_id, rsp_err;
  logic [31:0] alu_a, alu_b, alu_sum, rsp_data;
  logic [2:0]  alu_op;
  logic        alu_zout;

  logic        req0_ready_f, req1_ready_f, rsp_valid_f, rsp_zero_f, rsp_id_f, rsp_err_f;
  logic [31:0] alu_a_f, alu_b_f, alu_sum_f, rsp_data_f;
  logic [2:0]  alu_op_f;
  logic        alu_zout_f;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Reference ALU; unknown codes return a marker so sampling them is visible.
  function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b100:  return a >> b[4:0];
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_sum    = alu_model(alu_op, alu_a, alu_b);
  assign alu_zout   = (alu_sum == 32'd0);
  assign alu_sum_f  = alu_model(alu_op_f, alu_a_f, alu_b_f);
  assign alu_zout_f = (alu_sum_f == 32'd0);

  alu_share_arbiter #(.RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_sum(alu_sum), .alu_zout(alu_zout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .rsp_id(rsp_id), .rsp_err(rsp_err)
  );

  alu_share_arbiter #(.RR_EN(1'b0)) dut_fix (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready_f), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready_f), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_a(alu_a_f), .alu_b(alu_b_f), .alu_op(alu_op_f), .alu_sum(alu_sum_f), .alu_zout(alu_zout_f),
    .rsp_valid(rsp_valid_f), .rsp_ready(rsp_ready), .rsp_data(rsp_data_f), .rsp_zero(rsp_zero_f),
    .rsp_id(rsp_id_f), .rsp_err(rsp_err_f)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        id;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_data;
    logic        exp_zero;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic drive_req(input logic id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
  endtask

  task automatic scramble_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = 3'b001; req1_op = 3'b001;
    req0_a = 32'hFFFF_FFFF; req0_b = 32'hFFFF_FFFF;
    req1_a = 32'hFFFF_FFFF; req1_b = 32'hFFFF_FFFF;
  endtask

  // One full transaction with rsp_ready held high: handshake, EXEC, RESP, back to IDLE.
  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    @(negedge clk);
    drive_req(v.id, v.op, v.a, v.b);
    #1;
    chk($sformatf("v%0d_ready", i), {31'd0, v.id ? req1_ready : req0_ready}, 32'd1);
    @(posedge clk);
    #1;
    scramble_inputs();
    @(negedge clk);
    chk($sformatf("v%0d_alu_op", i), {29'd0, alu_op}, {29'd0, v.op});
    chk($sformatf("v%0d_alu_a", i), alu_a, v.a);
    chk($sformatf("v%0d_alu_b", i), alu_b, v.b);
    chk($sformatf("v%0d_exec_rdy", i), {30'd0, req1_ready, req0_ready}, 32'd0);
    chk($sformatf("v%0d_exec_vld", i), {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk($sformatf("v%0d_rsp_valid", i), {31'd0, rsp_valid}, 32'd1);
    chk($sformatf("v%0d_rsp_data", i), rsp_data, v.exp_data);
    chk($sformatf("v%0d_rsp_zero", i), {31'd0, rsp_zero}, {31'd0, v.exp_zero});
    chk($sformatf("v%0d_rsp_id", i), {31'd0, rsp_id}, {31'd0, v.id});
    chk($sformatf("v%0d_rsp_err", i), {31'd0, rsp_err}, {31'd0, v.exp_err});
    chk($sformatf("v%0d_resp_alu_op", i), {29'd0, alu_op}, 32'd0);
    @(negedge clk);
    chk($sformatf("v%0d_rsp_drop", i), {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    logic g_rr, g_fx, seen;
    vecs[0] = '{id:1'b0, op:3'b010, a:32'd5,          b:32'd7,          exp_data:32'd12,         exp_zero:1'b0, exp_err:1'b0};
    vecs[1] = '{id:1'b1, op:3'b110, a:32'd9,          b:32'd9,          exp_data:32'd0,          exp_zero:1'b1, exp_err:1'b0};
    vecs[2] = '{id:1'b1, op:3'b111, a:32'd3,          b:32'd8,          exp_data:32'd1,          exp_zero:1'b0, exp_err:1'b0};
    vecs[3] = '{id:1'b0, op:3'b111, a:32'hFFFF_FFFF,  b:32'd1,          exp_data:32'd1,          exp_zero:1'b0, exp_err:1'b0};
    vecs[4] = '{id:1'b0, op:3'b110, a:32'd3,          b:32'd5,          exp_data:32'hFFFF_FFFE,  exp_zero:1'b0, exp_err:1'b0};
    vecs[5] = '{id:1'b1, op:3'b000, a:32'h0000_F0F0,  b:32'h0000_0FF0,  exp_data:32'h0000_00F0,  exp_zero:1'b0, exp_err:1'b0};
    vecs[6] = '{id:1'b0, op:3'b001, a:32'h0000_00FF,  b:32'h0000_FF00,  exp_data:32'h0000_FFFF,  exp_zero:1'b0, exp_err:1'b0};
    vecs[7] = '{id:1'b1, op:3'b100, a:32'h8000_0000,  b:32'd4,          exp_data:32'h0800_0000,  exp_zero:1'b0, exp_err:1'b0};
    vecs[8] = '{id:1'b0, op:3'b011, a:32'd5,          b:32'd7,          exp_data:32'd0,          exp_zero:1'b1, exp_err:1'b1};
    vecs[9] = '{id:1'b1, op:3'b101, a:32'd1,          b:32'd2,          exp_data:32'd0,          exp_zero:1'b1, exp_err:1'b1};

    scramble_inputs();
    rsp_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_flags", {28'd0, rsp_zero, rsp_id, rsp_err, 1'b0}, 32'd0);
    chk("rst_alu", {alu_op, 29'd0} | alu_a | alu_b, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(i);

    // Both requesters valid continuously from reset: RR alternates, fixed priority stays on 0.
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    drive_req(1'b0, 3'b010, 32'd1, 32'd1);
    drive_req(1'b1, 3'b010, 32'd2, 32'd2);
    #1;
    for (int k = 0; k < 4; k++) begin
      seen = 1'b0;
      for (int n = 0; n < 6; n++) begin
        if (req0_ready || req1_ready) begin
          seen = 1'b1;
          break;
        end
        @(negedge clk);
        #1;
      end
      chk($sformatf("arb%0d_seen", k), {31'd0, seen}, 32'd1);
      g_rr = req1_ready;
      g_fx = req1_ready_f;
      chk($sformatf("arb%0d_rr_grant", k), {31'd0, g_rr}, k % 2);
      chk($sformatf("arb%0d_fix_grant", k), {30'd0, req1_ready_f, req0_ready_f}, 32'd1);
      chk($sformatf("arb%0d_fix_id", k), {31'd0, g_fx}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      #1;
    end
    scramble_inputs();
    repeat (4) @(negedge clk);

    // Backpressure: result held 5 cycles, new request blocked until release.
    drive_req(1'b0, 3'b010, 32'd1, 32'd1);
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    drive_req(1'b0, 3'b110, 32'd50, 32'd7);
    @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("hold%0d_valid", c), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("hold%0d_data", c), rsp_data, 32'd2);
      chk($sformatf("hold%0d_flags", c), {29'd0, rsp_zero, rsp_id, rsp_err}, 32'd0);
      chk($sformatf("hold%0d_ready", c), {30'd0, req1_ready, req0_ready}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_release_valid", {31'd0, rsp_valid}, 32'd0);
    chk("hold_release_ready", {31'd0, req0_ready}, 32'd1);
    scramble_inputs();
    repeat (4) @(negedge clk);

    // Reset during EXEC aborts the operation; no response follows.
    drive_req(1'b1, 3'b010, 32'd4, 32'd4);
    @(posedge clk);
    #1;
    scramble_inputs();
    @(negedge clk);
    chk("abort_exec_op", {29'd0, alu_op}, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("abort_alu", {alu_op, 29'd0} | alu_a | alu_b, 32'd0);
    chk("abort_rsp_data", rsp_data, 32'd0);
    chk("abort_flags", {29'd0, rsp_zero, rsp_id, rsp_err}, 32'd0);
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("abort_no_rsp%0d", c), {31'd0, rsp_valid}, 32'd0);
    end

    // First rising edge after reset release already takes a handshake.
    rst_n = 1'b0;
    drive_req(1'b0, 3'b010, 32'd6, 32'd6);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    scramble_inputs();
    chk("first_edge_op", {29'd0, alu_op}, 32'd2);
    chk("first_edge_a", alu_a, 32'd6);
    @(negedge clk);
    @(negedge clk);
    chk("first_edge_rsp", rsp_data, 32'd12);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
